// File: rtl/numpad_pkg.sv
// Shared definitions for the numpad decoder: op codes, event bit positions
// and the main-keyboard index map.
package numpad_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_EQ  = 3'd4,
    OP_CLR = 3'd5
  } op_t;

  localparam int EV_VALID = 5;
  localparam int EV_MAIN  = 4;

  // An all-zero event word is "no event".
  localparam logic [5:0] BTN_EMPTY = 6'b00_0000;

  localparam logic [3:0] ALT_BACKSPACE = 4'd0;
  localparam logic [3:0] ALT_NEGATE    = 4'd4;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_op;
    op_t        op;
  } key_t;

  function automatic key_t decode_main(input logic [3:0] idx);
    key_t k;
    k = '{is_digit: 1'b0, digit: 4'd0, is_op: 1'b0, op: OP_ADD};
    case (idx)
      4'd0:  begin k.is_digit = 1'b1; k.digit = 4'd1; end
      4'd4:  begin k.is_digit = 1'b1; k.digit = 4'd2; end
      4'd8:  begin k.is_digit = 1'b1; k.digit = 4'd3; end
      4'd1:  begin k.is_digit = 1'b1; k.digit = 4'd4; end
      4'd5:  begin k.is_digit = 1'b1; k.digit = 4'd5; end
      4'd9:  begin k.is_digit = 1'b1; k.digit = 4'd6; end
      4'd2:  begin k.is_digit = 1'b1; k.digit = 4'd7; end
      4'd6:  begin k.is_digit = 1'b1; k.digit = 4'd8; end
      4'd10: begin k.is_digit = 1'b1; k.digit = 4'd9; end
      4'd3:  begin k.is_digit = 1'b1; k.digit = 4'd0; end
      4'd12: begin k.is_op = 1'b1; k.op = OP_ADD; end
      4'd13: begin k.is_op = 1'b1; k.op = OP_SUB; end
      4'd14: begin k.is_op = 1'b1; k.op = OP_MUL; end
      4'd15: begin k.is_op = 1'b1; k.op = OP_DIV; end
      4'd11: begin k.is_op = 1'b1; k.op = OP_EQ;  end
      default: begin k.is_op = 1'b1; k.op = OP_CLR; end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for scanner events; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module key_event_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   cnt_reg;
  logic          do_push, do_pop;

  assign full     = (cnt_reg == (AW+1)'(DEPTH));
  assign empty    = (cnt_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/numpad_decoder.sv
// Numpad key events -> BCD entry -> {op, signed operand} tokens.
// Define NUMPAD_DECODER_KEY_FIFO_EN to buffer events in a 4-entry FIFO.
module numpad_decoder
  import numpad_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int OUT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [5:0]              key_event,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_op,
  output logic [OUT_W-1:0]        out_operand,
  output logic                    out_has_operand,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic                    entry_neg,
  output logic                    entry_full,
  output logic                    dropped
);

  localparam int     CW      = $clog2(MAX_DIGITS + 1);
  localparam longint MAX_MAG = 10**MAX_DIGITS - 1;
  localparam longint OUT_LIM = longint'(1) << (OUT_W - 1);

  generate
    if (OUT_LIM <= MAX_MAG) begin : g_width_check
      $error("OUT_W too narrow to hold MAX_DIGITS decimal digits");
    end
  endgenerate

  typedef enum logic [1:0] {ENTRY, CONVERT, SEND} state_t;

  state_t                  state_reg, state_next;
  logic [4*MAX_DIGITS-1:0] bcd_reg, bcd_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [CW-1:0]           idx_reg, idx_next;
  logic                    neg_reg, neg_next;
  logic                    has_reg, has_next;
  op_t                     op_reg, op_next;
  logic [OUT_W-1:0]        acc_reg, acc_next;
  logic [OUT_W-1:0]        operand_reg, operand_next;
  logic                    has_op_reg, has_op_next;
  logic                    valid_reg, valid_next;
  logic                    dropped_reg, dropped_next;

  logic [5:0] ev;
  logic       lost;
  logic [3:0] conv_digit;
  key_t       k;

`ifdef NUMPAD_DECODER_KEY_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [5:0] fifo_data;

  assign fifo_pop = (state_reg == ENTRY) && !fifo_empty;

  key_event_fifo #(.W(6), .DEPTH(4)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (key_event[EV_VALID]),
    .push_data (key_event),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev   = fifo_pop ? fifo_data : BTN_EMPTY;
  assign lost = key_event[EV_VALID] && fifo_full && !fifo_pop;
`else
  assign ev   = (state_reg == ENTRY) ? key_event : BTN_EMPTY;
  assign lost = key_event[EV_VALID] && (state_reg != ENTRY);
`endif

  // MSD first: idx counts down from MAX_DIGITS-1.
  assign conv_digit = bcd_reg[4*idx_reg +: 4];

  always_comb begin
    state_next   = state_reg;
    bcd_next     = bcd_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    neg_next     = neg_reg;
    has_next     = has_reg;
    op_next      = op_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    has_op_next  = has_op_reg;
    valid_next   = valid_reg;
    dropped_next = dropped_reg | lost;
    k            = decode_main(ev[3:0]);

    case (state_reg)
      ENTRY: begin
        if (ev[EV_VALID]) begin
          if (ev[EV_MAIN]) begin
            if (k.is_digit) begin
              if (count_reg < CW'(MAX_DIGITS)) begin
                bcd_next = (bcd_reg << 4) | {{(4*MAX_DIGITS-4){1'b0}}, k.digit};
                has_next = 1'b1;
                if (!(k.digit == 4'd0 && count_reg == '0))
                  count_next = count_reg + 1'b1;
              end
            end else if (k.is_op) begin
              op_next    = k.op;
              acc_next   = '0;
              idx_next   = CW'(MAX_DIGITS - 1);
              state_next = CONVERT;
            end
          end else if (ev[3:0] == ALT_BACKSPACE) begin
            bcd_next = bcd_reg >> 4;
            if (count_reg != '0) count_next = count_reg - 1'b1;
            if (count_reg <= CW'(1)) has_next = 1'b0;
          end else if (ev[3:0] == ALT_NEGATE) begin
            neg_next = !neg_reg;
          end
        end
      end
      CONVERT: begin
        acc_next = acc_reg * OUT_W'(10) + OUT_W'(conv_digit);
        if (idx_reg == '0) state_next = SEND;
        else idx_next = idx_reg - 1'b1;
      end
      SEND: begin
        // First SEND cycle applies the sign; the token is visible from the next.
        if (!valid_reg) begin
          valid_next   = 1'b1;
          operand_next = neg_reg ? -acc_reg : acc_reg;
          has_op_next  = has_reg;
        end else if (out_ready) begin
          valid_next = 1'b0;
          state_next = ENTRY;
          bcd_next   = '0;
          count_next = '0;
          neg_next   = 1'b0;
          has_next   = 1'b0;
          if (op_reg == OP_CLR) dropped_next = lost;
        end
      end
      default: state_next = ENTRY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ENTRY;
      bcd_reg     <= '0;
      count_reg   <= '0;
      idx_reg     <= '0;
      neg_reg     <= 1'b0;
      has_reg     <= 1'b0;
      op_reg      <= OP_ADD;
      acc_reg     <= '0;
      operand_reg <= '0;
      has_op_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bcd_reg     <= bcd_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      neg_reg     <= neg_next;
      has_reg     <= has_next;
      op_reg      <= op_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      has_op_reg  <= has_op_next;
      valid_reg   <= valid_next;
      dropped_reg <= dropped_next;
    end
  end

  assign out_valid       = valid_reg;
  assign out_op          = op_reg;
  assign out_operand     = operand_reg;
  assign out_has_operand = has_op_reg;
  assign entry_bcd       = bcd_reg;
  assign entry_neg       = neg_reg;
  assign entry_full      = (count_reg == CW'(MAX_DIGITS));
  assign dropped         = dropped_reg;

endmodule

// File: tb/tb_numpad_decoder.sv
// Directed bench for numpad_decoder with a value-level entry/token model.
// Also exercises the NUMPAD_DECODER_KEY_FIFO_EN build when that macro is defined.
module tb_numpad_decoder;

`ifdef NUMPAD_DECODER_KEY_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif
  localparam int LAT = FIFO_MODE ? 6 : 5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  key_event;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_op;
  logic [15:0] out_operand;
  logic        out_has_operand;
  logic [15:0] entry_bcd;
  logic        entry_neg;
  logic        entry_full;
  logic        dropped;

  always #10 clock = ~clock;

  numpad_decoder #(.MAX_DIGITS(4), .OUT_W(16)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .key_event       (key_event),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_op          (out_op),
    .out_operand     (out_operand),
    .out_has_operand (out_has_operand),
    .entry_bcd       (entry_bcd),
    .entry_neg       (entry_neg),
    .entry_full      (entry_full),
    .dropped         (dropped)
  );

  int cmp_n  = 0;
  int fail_n = 0;
  bit run    = 1'b0;

  // Main keyboard index -> digit 0..9, or 10+op code.
  int main_map [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

  int         m_val, m_op, m_tok, m_since;
  bit         m_neg, m_has, m_busy, m_vexp, m_drop, m_tok_has;
  logic [5:0] m_q [$];

  function automatic int ndig(input int v);
    if (v == 0) return 0;
    if (v < 10) return 1;
    if (v < 100) return 2;
    if (v < 1000) return 3;
    return 4;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      fail_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_val = 0; m_neg = 0; m_has = 0; m_busy = 0; m_vexp = 0; m_drop = 0;
    m_op = 0; m_tok = 0; m_tok_has = 0; m_since = 0;
    m_q.delete();
  endtask

  task automatic apply_event(input logic [5:0] e);
    int code;
    if (e[4]) begin
      code = main_map[e[3:0]];
      if (code < 10) begin
        if (ndig(m_val) < 4) begin
          m_val = m_val * 10 + code;
          m_has = 1;
        end
      end else begin
        m_op = code - 10;
        m_busy = 1;
        m_since = 0;
        m_tok = m_neg ? -m_val : m_val;
        m_tok_has = m_has;
      end
    end else if (e[3:0] == 4'd0) begin
      m_val = m_val / 10;
      if (m_val == 0) m_has = 0;
    end else if (e[3:0] == 4'd4) begin
      m_neg = !m_neg;
    end
  endtask

  // Advances the model across one rising edge using the inputs seen there.
  task automatic model_edge();
    bit busy_pre, acc, lost;
    logic [5:0] e;
    if (!reset_n) begin
      model_clear();
      return;
    end
    busy_pre = m_busy;
    acc = m_vexp && out_ready;
    lost = 0;
    e = 6'h00;
    if (FIFO_MODE) begin
      if (!busy_pre && m_q.size() > 0) e = m_q.pop_front();
      if (key_event[5]) begin
        if (m_q.size() < 4) m_q.push_back(key_event);
        else lost = 1;
      end
    end else if (key_event[5]) begin
      if (busy_pre) lost = 1;
      else e = key_event;
    end
    if (busy_pre && !m_vexp) begin
      m_since++;
      if (m_since == 5) m_vexp = 1;
    end
    if (acc) begin
      if (m_op == 5) m_drop = 0;
      m_busy = 0; m_vexp = 0; m_val = 0; m_neg = 0; m_has = 0;
    end
    m_drop = m_drop | lost;
    if (!busy_pre && e[5]) apply_event(e);
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("out_valid", int'(out_valid), int'(m_vexp));
      chk("entry_bcd", int'(entry_bcd), to_bcd(m_val));
      chk("entry_neg", int'(entry_neg), int'(m_neg));
      chk("entry_full", int'(entry_full), int'(ndig(m_val) == 4));
      chk("dropped", int'(dropped), int'(m_drop));
      if (m_vexp) begin
        chk("out_op", int'(out_op), m_op);
        chk("out_operand", int'($signed(out_operand)), m_tok);
        chk("out_has_operand", int'(out_has_operand), int'(m_tok_has));
      end
      if (out_valid && out_ready)
        $display("token accepted: op=%0d operand=%0d has_operand=%0d",
                 out_op, $signed(out_operand), out_has_operand);
    end
  end

  task automatic cyc(input logic [5:0] e, input bit r);
    key_event = e;
    out_ready = r;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Called right after the operator edge; checks the issue latency.
  task automatic wait_valid(input bit r);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      cyc(6'h00, r);
      n++;
    end
    chk("token_latency", n, LAT);
  endtask

  initial begin
    model_clear();
    reset_n = 1'b0;
    cyc(6'h00, 1'b0);
    cyc(6'h00, 1'b0);
    run = 1'b1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_bcd", int'(entry_bcd), 0);
    chk("reset_dropped", int'(dropped), 0);
    reset_n = 1'b1;
    cyc(6'h00, 1'b0);

    // 1,2,3 ADD with ready held high
    cyc(6'h30, 1'b1); cyc(6'h34, 1'b1); cyc(6'h38, 1'b1);
    chk("t1_bcd", int'(entry_bcd), 16'h0123);
    cyc(6'h3C, 1'b1);
    wait_valid(1'b1);
    chk("t1_op", int'(out_op), 0);
    chk("t1_operand", int'($signed(out_operand)), 123);
    chk("t1_has", int'(out_has_operand), 1);
    cyc(6'h00, 1'b1);
    chk("t1_cleared", int'(entry_bcd), 0);
    chk("t1_valid_low", int'(out_valid), 0);

    // five 9s (fifth ignored), NEGATE, EQ
    repeat (5) cyc(6'h3A, 1'b0);
    cyc(6'h24, 1'b0);
    chk("t2_full", int'(entry_full), 1);
    chk("t2_bcd", int'(entry_bcd), 16'h9999);
    cyc(6'h3B, 1'b0);
    wait_valid(1'b0);
    chk("t2_op", int'(out_op), 4);
    chk("t2_operand", int'($signed(out_operand)), -9999);
    cyc(6'h00, 1'b1);

    // 4,5,BACKSPACE,6, MUL held for 10 cycles
    cyc(6'h31, 1'b0); cyc(6'h35, 1'b0); cyc(6'h20, 1'b0); cyc(6'h39, 1'b0);
    chk("t3_bcd", int'(entry_bcd), 16'h0046);
    cyc(6'h3E, 1'b0);
    wait_valid(1'b0);
    repeat (10) cyc(6'h00, 1'b0);
    chk("t3_held_valid", int'(out_valid), 1);
    chk("t3_op", int'(out_op), 2);
    chk("t3_operand", int'($signed(out_operand)), 46);
    cyc(6'h00, 1'b1);
    chk("t3_valid_low", int'(out_valid), 0);

    // DIV on an empty entry, then a digit during SEND, then CLR
    cyc(6'h20, 1'b0);
    cyc(6'h3F, 1'b0);
    wait_valid(1'b0);
    chk("t4_op", int'(out_op), 3);
    chk("t4_operand", int'($signed(out_operand)), 0);
    chk("t4_has", int'(out_has_operand), 0);
    cyc(6'h30, 1'b0);
    cyc(6'h00, 1'b0);
    chk("t4_dropped", int'(dropped), FIFO_MODE ? 0 : 1);
    chk("t4_bcd_kept", int'(entry_bcd), 0);
    cyc(6'h00, 1'b1);
    cyc(6'h37, 1'b0);
    wait_valid(1'b0);
    chk("t4_clr_op", int'(out_op), 5);
    cyc(6'h00, 1'b1);
    cyc(6'h00, 1'b0);
    chk("t4_clr_dropped", int'(dropped), 0);

    // leading zero, negate on empty, ignored alt key, non-event word, SUB
    cyc(6'h33, 1'b1);
    chk("t5_zero_full", int'(entry_full), 0);
    cyc(6'h24, 1'b1); cyc(6'h21, 1'b1); cyc(6'h1F, 1'b1);
    chk("t5_neg", int'(entry_neg), 1);
    cyc(6'h3D, 1'b1);
    wait_valid(1'b1);
    chk("t5_op", int'(out_op), 1);
    chk("t5_operand", int'($signed(out_operand)), 0);
    chk("t5_has", int'(out_has_operand), 1);
    cyc(6'h00, 1'b1);

    // reset in the middle of CONVERT
    cyc(6'h32, 1'b1); cyc(6'h3C, 1'b1);
    repeat (FIFO_MODE ? 3 : 2) cyc(6'h00, 1'b1);
    reset_n = 1'b0;
    cyc(6'h00, 1'b1);
    reset_n = 1'b1;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_bcd", int'(entry_bcd), 0);
    repeat (8) cyc(6'h00, 1'b1);
    chk("t6_no_token", int'(out_valid), 0);

    if (FIFO_MODE) begin
      // three events back-to-back while a token waits
      cyc(6'h3C, 1'b0);
      wait_valid(1'b0);
      cyc(6'h30, 1'b0); cyc(6'h34, 1'b0); cyc(6'h38, 1'b0);
      chk("f_no_drop", int'(dropped), 0);
      cyc(6'h00, 1'b1);
      repeat (4) cyc(6'h00, 1'b0);
      chk("f_bcd", int'(entry_bcd), 16'h0123);
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
